vip_bit_morph_nxn: RTL

Parametrised binary morphology engine for the 1-bit video path (after binarisation, before the projection/face-box logic). It builds a KSIZE x KSIZE window from internal line buffers. Per frame it applies erosion (AND of window), dilation (OR of window) or bypass, with defined border padding. Drop-in successor for the fixed 3x3 erosion/dilation detectors: same stream interface, same fixed 2-clock sync latency.

---
 rtl/vip_bit_morph_nxn.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vip_bit_morph_nxn.sv
// KSIZE x KSIZE binary erosion/dilation/bypass for the 1-bit video path.
// Line buffers and border padding feed a two-stage pipeline with a fixed two-clock latency.
module vip_bit_morph_nxn #(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int KSIZE       = 3,
    parameter int BORDER_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic [1:0] frame_mode
);

    localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam int NL = KSIZE - 1;
    localparam logic [1:0] MODE_ERODE  = 2'b01;
    localparam logic [1:0] MODE_DILATE = 2'b10;

    if (KSIZE != 3 && KSIZE != 5) begin : g_ksize_check
        $error("vip_bit_morph_nxn: KSIZE must be 3 or 5");
    end

    logic                     vsync_q_r, href_q_r;
    logic                     acc_s, vs_rise_s, href_fall_s, pad_s;
    logic [CW-1:0]            col_r, cur_col_s;
    logic [RW-1:0]            row_r, cur_row_s;
    logic [1:0]               frame_mode_r, pix_mode_s, mode_s1_r;
    logic [IMG_HDISP-1:0]     lb_r [NL];
    logic [NL-1:0]            hist_r [KSIZE];
    logic [KSIZE-1:0]         vert_s;
    logic [KSIZE*KSIZE-1:0]   tap_s;
    logic [KSIZE-1:0]         row_and_r, row_or_r;
    logic                     bit_s1_r, result_s, post_bit_r;
    logic [2:0]               sync_d1_r, sync_d2_r;

    function automatic logic [CW-1:0] col_sat_inc(input logic [CW-1:0] c);
        return (c == CW'(IMG_HDISP - 1)) ? c : c + CW'(1);
    endfunction

    function automatic logic [RW-1:0] row_sat_inc(input logic [RW-1:0] r);
        return (r == RW'(IMG_VDISP - 1)) ? r : r + RW'(1);
    endfunction

    // Event decode; a vsync rise in the same clock as a pixel makes that pixel (0,0) of the new frame
    always_comb begin
        acc_s       = per_frame_href & per_frame_clken;
        vs_rise_s   = per_frame_vsync & ~vsync_q_r;
        href_fall_s = ~per_frame_href & href_q_r;
        cur_col_s   = vs_rise_s ? '0 : col_r;
        cur_row_s   = vs_rise_s ? '0 : row_r;
        pix_mode_s  = vs_rise_s ? mode : frame_mode_r;
        if (BORDER_MODE == 1) begin
            pad_s = 1'b0;
        end else begin
            pad_s = (pix_mode_s == MODE_ERODE);
        end
    end

    // Column source of each window row: current pixel at the bottom, line buffers above it
    assign vert_s[KSIZE-1] = per_img_Bit;
    for (genvar gl = 0; gl < NL; gl++) begin : g_vert
        assign vert_s[NL-1-gl] = lb_r[gl][IMG_HDISP-1];
    end

    // Window taps; anything above row 0 or left of col 0 is replaced by the pad value
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KSIZE; gj++) begin : g_col
            localparam int RP = NL - gi;
            localparam int CP = NL - gj;
            logic row_pad_s, col_pad_s, raw_s;
            if (RP > 0) begin : g_rp
                assign row_pad_s = (int'(cur_row_s) < RP);
            end else begin : g_rn
                assign row_pad_s = 1'b0;
            end
            if (CP > 0) begin : g_cp
                assign col_pad_s = (int'(cur_col_s) < CP);
                assign raw_s     = hist_r[gi][gj];
            end else begin : g_cn
                assign col_pad_s = 1'b0;
                assign raw_s     = vert_s[gi];
            end
            assign tap_s[gi*KSIZE+gj] = (row_pad_s | col_pad_s) ? pad_s : raw_s;
        end
    end

    // Edge history, per-frame mode latch and pixel coordinate counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r    <= 1'b0;
            href_q_r     <= 1'b0;
            frame_mode_r <= 2'b00;
            col_r        <= '0;
            row_r        <= '0;
        end else begin
            vsync_q_r <= per_frame_vsync;
            href_q_r  <= per_frame_href;
            if (vs_rise_s) begin
                frame_mode_r <= mode;
                row_r        <= '0;
                col_r        <= acc_s ? col_sat_inc('0) : '0;
            end else if (href_fall_s) begin
                col_r <= '0;
                row_r <= row_sat_inc(row_r);
            end else if (acc_s) begin
                col_r <= col_sat_inc(col_r);
            end else begin
                col_r <= col_r;
            end
        end
    end

    // Line buffers and per-row horizontal history, advanced only by accepted pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) lb_r[l] <= '0;
            for (int i = 0; i < KSIZE; i++) hist_r[i] <= '0;
        end else if (acc_s) begin
            lb_r[0] <= {lb_r[0][IMG_HDISP-2:0], per_img_Bit};
            for (int l = 1; l < NL; l++) lb_r[l] <= {lb_r[l][IMG_HDISP-2:0], lb_r[l-1][IMG_HDISP-1]};
            for (int i = 0; i < KSIZE; i++) hist_r[i] <= {vert_s[i], hist_r[i][NL-1:1]};
        end
    end

    // Stage 1: per-row AND/OR of the padded window plus the bypass bit and its frame mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_and_r <= '0;
            row_or_r  <= '0;
            bit_s1_r  <= 1'b0;
            mode_s1_r <= 2'b00;
        end else if (acc_s) begin
            for (int i = 0; i < KSIZE; i++) begin
                row_and_r[i] <= &tap_s[i*KSIZE +: KSIZE];
                row_or_r[i]  <= |tap_s[i*KSIZE +: KSIZE];
            end
            bit_s1_r  <= per_img_Bit;
            mode_s1_r <= pix_mode_s;
        end
    end

    // Stage 2 combine and mode select
    always_comb begin
        case (mode_s1_r)
            MODE_ERODE:  result_s = &row_and_r;
            MODE_DILATE: result_s = |row_or_r;
            default:     result_s = bit_s1_r;
        endcase
    end

    // Stage 2 register with href gating, and the plain sync delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d1_r  <= 3'b000;
            sync_d2_r  <= 3'b000;
            post_bit_r <= 1'b0;
        end else begin
            sync_d1_r <= {per_frame_vsync, per_frame_href, per_frame_clken};
            sync_d2_r <= sync_d1_r;
            if (!sync_d1_r[1]) begin
                post_bit_r <= 1'b0;
            end else if (sync_d1_r[0]) begin
                post_bit_r <= result_s;
            end else begin
                post_bit_r <= post_bit_r;
            end
        end
    end

    assign post_frame_vsync = sync_d2_r[2];
    assign post_frame_href  = sync_d2_r[1];
    assign post_frame_clken = sync_d2_r[0];
    assign post_img_Bit     = post_bit_r;
    assign frame_mode       = frame_mode_r;

endmodule
